// File: rtl/topk_abs_tracker.sv
// Streaming top-K tracker: keeps the K largest correlation keys of a sweep as a
// sorted (index, key) list, with skip support and a start/done handshake.
module topk_abs_tracker #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned K        = 4,
  parameter int unsigned ABS_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_value,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_skip,
  input  logic                  in_last,
  output logic                  busy,
  output logic                  done,
  output logic [K-1:0]          top_vld,
  output logic [K*IDX_W-1:0]    top_idx,
  output logic [K*DATA_W-1:0]   top_mag
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Flipping the sign bit turns a signed compare into an unsigned one.
  localparam logic [DATA_W-1:0] SIGN_BIT  = DATA_W'(1) << (DATA_W - 1);
  localparam logic [DATA_W-1:0] RANK_FLIP = (ABS_MODE != 0) ? '0 : SIGN_BIT;

  state_t              state, state_n;
  logic                accept;
  logic [DATA_W-1:0]   new_key;
  logic [K-1:0]        ge;
  logic [IDX_W-1:0]    idx_q [K];
  logic [DATA_W-1:0]   mag_q [K];
  logic                vld_q [K];

  assign accept = in_valid && in_ready && !start;

  // |value| fits DATA_W bits unsigned, so the most negative input maps cleanly.
  always_comb begin
    new_key = in_value;
    if ((ABS_MODE != 0) && in_value[DATA_W-1]) begin
      new_key = DATA_W'(~in_value) + DATA_W'(1);
    end
  end

  // Entries at or above the new key stay put; ties favour the earlier sample.
  always_comb begin
    ge = '0;
    for (int k = 0; k < K; k++) begin
      ge[k] = vld_q[k] && ((mag_q[k] ^ RANK_FLIP) >= (new_key ^ RANK_FLIP));
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (start) state_n = SCAN;
               else if (accept && in_last) state_n = DONE;
      DONE:    state_n = start ? SCAN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == SCAN);
      busy     <= (state_n == SCAN);
      done     <= (state_n == DONE);
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_ent
    logic              above;
    logic              prev_vld;
    logic [IDX_W-1:0]  prev_idx;
    logic [DATA_W-1:0] prev_mag;

    if (g == 0) begin : g_head
      assign above    = 1'b1;
      assign prev_vld = 1'b0;
      assign prev_idx = '0;
      assign prev_mag = '0;
    end else begin : g_tail
      assign above    = ge[g-1];
      assign prev_vld = vld_q[g-1];
      assign prev_idx = idx_q[g-1];
      assign prev_mag = mag_q[g-1];
    end

    // Insertion point takes the new sample; entries below it shift down one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[g] <= 1'b0;
        idx_q[g] <= '0;
        mag_q[g] <= '0;
      end else if (start) begin
        vld_q[g] <= 1'b0;
        idx_q[g] <= '0;
        mag_q[g] <= '0;
      end else if (accept && !in_skip && !ge[g]) begin
        if (above) begin
          vld_q[g] <= 1'b1;
          idx_q[g] <= in_idx;
          mag_q[g] <= new_key;
        end else begin
          vld_q[g] <= prev_vld;
          idx_q[g] <= prev_idx;
          mag_q[g] <= prev_mag;
        end
      end
    end

    assign top_vld[g]                   = vld_q[g];
    assign top_idx[g*IDX_W +: IDX_W]    = idx_q[g];
    assign top_mag[g*DATA_W +: DATA_W]  = mag_q[g];
  end

endmodule

// File: tb/tb_topk_abs_tracker.sv
// Directed bench for topk_abs_tracker: table of sweeps on an |value| instance,
// plus restart, signed-mode and mid-sweep reset sequences.
module tb_topk_abs_tracker;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned K      = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, in_valid, in_skip, in_last;
  logic [DATA_W-1:0]   in_value;
  logic [IDX_W-1:0]    in_idx;
  logic                in_ready, busy, done;
  logic [K-1:0]        top_vld;
  logic [K*IDX_W-1:0]  top_idx;
  logic [K*DATA_W-1:0] top_mag;
  logic                s_in_ready, s_busy, s_done;
  logic [K-1:0]        s_top_vld;
  logic [K*IDX_W-1:0]  s_top_idx;
  logic [K*DATA_W-1:0] s_top_mag;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  topk_abs_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K), .ABS_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_idx(in_idx), .in_skip(in_skip), .in_last(in_last),
    .busy(busy), .done(done), .top_vld(top_vld), .top_idx(top_idx), .top_mag(top_mag));

  topk_abs_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K), .ABS_MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_value(in_value), .in_idx(in_idx), .in_skip(in_skip), .in_last(in_last),
    .busy(s_busy), .done(s_done), .top_vld(s_top_vld), .top_idx(s_top_idx), .top_mag(s_top_mag));

  typedef struct packed {
    logic [2:0]        n;
    logic [4:0][15:0]  val;
    logic [4:0][7:0]   idx;
    logic [4:0]        skip;
    logic [3:0][7:0]   eidx;
    logic [3:0][15:0]  emag;
    logic [3:0]        evld;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input logic [7:0] i, input logic s, input logic l);
    in_valid = 1'b1; in_value = v; in_idx = i; in_skip = s; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_skip = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    pulse_start();
    check($sformatf("v%0d busy", n), 64'(busy), 64'd1);
    check($sformatf("v%0d ready", n), 64'(in_ready), 64'd1);
    for (int i = 0; i < int'(v.n); i++) begin
      send(v.val[i], v.idx[i], v.skip[i], i == int'(v.n) - 1);
    end
    check($sformatf("v%0d done", n), 64'(done), 64'd1);
    check($sformatf("v%0d ready_done", n), 64'(in_ready), 64'd0);
    check($sformatf("v%0d vld", n), 64'(top_vld), 64'(v.evld));
    check($sformatf("v%0d idx", n), 64'(top_idx), 64'(v.eidx));
    check($sformatf("v%0d mag", n), 64'(top_mag), 64'(v.emag));
    tick();
    check($sformatf("v%0d done_drop", n), 64'(done), 64'd0);
    check($sformatf("v%0d idx_held", n), 64'(top_idx), 64'(v.eidx));
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_skip = 1'b0; in_last = 1'b0;
    in_value = '0; in_idx = '0;

    vecs[0] = '0;
    vecs[0].n = 3'd5;
    vecs[0].val  = {16'hFFFE, 16'd9, 16'd5, 16'hFFF7, 16'd3};
    vecs[0].idx  = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[0].eidx = {8'd0, 8'd2, 8'd3, 8'd1};
    vecs[0].emag = {16'd3, 16'd5, 16'd9, 16'd9};
    vecs[0].evld = 4'b1111;
    vecs[1] = '0;
    vecs[1].n = 3'd3;
    vecs[1].val  = {16'd0, 16'd0, 16'h8000, 16'hFF38, 16'd100};
    vecs[1].idx  = {8'd0, 8'd0, 8'd7, 8'd6, 8'd5};
    vecs[1].eidx = {8'd0, 8'd5, 8'd6, 8'd7};
    vecs[1].emag = {16'd0, 16'd100, 16'd200, 16'h8000};
    vecs[1].evld = 4'b0111;
    vecs[2] = '0;
    vecs[2].n = 3'd5;
    vecs[2].val  = {16'd5, 16'd30, 16'd50, 16'hFFEC, 16'd10};
    vecs[2].idx  = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[2].skip = 5'b00100;
    vecs[2].eidx = {8'd4, 8'd0, 8'd1, 8'd3};
    vecs[2].emag = {16'd5, 16'd10, 16'd20, 16'd30};
    vecs[2].evld = 4'b1111;
    vecs[3] = '0;
    vecs[3].n = 3'd2;
    vecs[3].val  = {16'd0, 16'd0, 16'd0, 16'hFFF8, 16'd7};
    vecs[3].idx  = {8'd0, 8'd0, 8'd0, 8'd11, 8'd10};
    vecs[3].eidx = {8'd0, 8'd0, 8'd10, 8'd11};
    vecs[3].emag = {16'd0, 16'd0, 16'd7, 16'd8};
    vecs[3].evld = 4'b0011;
    vecs[4] = '0;
    vecs[4].n = 3'd2;
    vecs[4].val  = {16'd0, 16'd0, 16'd0, 16'd5, 16'd4};
    vecs[4].idx  = {8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    vecs[4].skip = 5'b00011;
    vecs[5] = '0;
    vecs[5].n = 3'd5;
    vecs[5].val  = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vecs[5].idx  = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[5].eidx = {8'd1, 8'd2, 8'd3, 8'd4};
    vecs[5].emag = {16'd2, 16'd3, 16'd4, 16'd5};
    vecs[5].evld = 4'b1111;

    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 64'(in_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst vld", 64'(top_vld), 64'd0);
    check("rst idx", 64'(top_idx), 64'd0);
    check("rst mag", 64'(top_mag), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle ready", 64'(in_ready), 64'd0);

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Restart mid-sweep, then restart again straight out of DONE.
    base = done_cnt;
    pulse_start();
    send(16'd40, 8'd20, 1'b0, 1'b0);
    send(16'd41, 8'd21, 1'b0, 1'b0);
    send(16'd42, 8'd22, 1'b0, 1'b0);
    start = 1'b1;
    send(16'd99, 8'd23, 1'b0, 1'b0);
    start = 1'b0;
    check("rs cleared", 64'(top_vld), 64'd0);
    send(16'd6, 8'd24, 1'b0, 1'b0);
    send(16'hFFF9, 8'd25, 1'b0, 1'b1);
    check("rs done", 64'(done), 64'd1);
    check("rs vld", 64'(top_vld), 64'h3);
    check("rs idx", 64'(top_idx), 64'({8'd0, 8'd0, 8'd24, 8'd25}));
    check("rs mag", 64'(top_mag), 64'({16'd0, 16'd0, 16'd6, 16'd7}));
    pulse_start();
    check("rs_done busy", 64'(busy), 64'd1);
    check("rs_done vld", 64'(top_vld), 64'd0);
    check("rs_done done", 64'(done), 64'd0);
    check("rs done count", 64'(done_cnt - base), 64'd1);

    // Signed ranking on the second instance; same sweep on the |value| one.
    pulse_start();
    send(16'hFFF7, 8'd0, 1'b0, 1'b0);
    send(16'd4, 8'd1, 1'b0, 1'b0);
    send(16'd0, 8'd2, 1'b0, 1'b1);
    check("sg done", 64'(s_done), 64'd1);
    check("sg vld", 64'(s_top_vld), 64'h7);
    check("sg idx", 64'(s_top_idx), 64'({8'd0, 8'd0, 8'd2, 8'd1}));
    check("sg mag", 64'(s_top_mag), 64'({16'd0, 16'hFFF7, 16'd0, 16'd4}));
    check("ab idx", 64'(top_idx), 64'({8'd0, 8'd2, 8'd1, 8'd0}));
    check("ab mag", 64'(top_mag), 64'({16'd0, 16'd0, 16'd4, 16'd9}));
    tick();

    // Asynchronous reset in the middle of a sweep.
    pulse_start();
    send(16'd11, 8'd3, 1'b0, 1'b0);
    send(16'd12, 8'd4, 1'b0, 1'b0);
    base = done_cnt;
    in_valid = 1'b1; in_value = 16'd13; in_idx = 8'd5; in_last = 1'b1;
    rst_n = 1'b0;
    #1;
    check("ar ready", 64'(in_ready), 64'd0);
    check("ar busy", 64'(busy), 64'd0);
    check("ar vld", 64'(top_vld), 64'd0);
    check("ar idx", 64'(top_idx), 64'd0);
    check("ar mag", 64'(top_mag), 64'd0);
    check("ar s_vld", 64'(s_top_vld), 64'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("ar no done", 64'(done_cnt - base), 64'd0);
    check("ar idle busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
